bram_port_arbiter: RTL

// - Shares one single-port block RAM between two requesters: port 0 (instruction fetch) and port 1 (data/LSU).
// - Sits between the requesters and the RAM; drives the RAM's we/addr/wdata and steers its registered rdata back.
// - Arbitrates per access, supports a lock for atomic read-modify-write, and tracks the 1-cycle read latency.

---
 rtl/bram_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester front end for one single-port BRAM: per-access arbitration, lock for atomic RMW,
// 1-cycle read-latency tracking. Define BRAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (port 0).
module bram_port_arbiter #(
  parameter int abits  = 8,
  parameter int dbytes = 4,
  parameter int blen   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p0_req,
  input  logic [dbytes-1:0]       p0_we,
  input  logic [abits-1:0]        p0_addr,
  input  logic [dbytes*blen-1:0]  p0_wdata,
  input  logic                    p0_lock,
  output logic                    p0_gnt,
  output logic                    p0_rvalid,
  output logic [dbytes*blen-1:0]  p0_rdata,
  input  logic                    p1_req,
  input  logic [dbytes-1:0]       p1_we,
  input  logic [abits-1:0]        p1_addr,
  input  logic [dbytes*blen-1:0]  p1_wdata,
  input  logic                    p1_lock,
  output logic                    p1_gnt,
  output logic                    p1_rvalid,
  output logic [dbytes*blen-1:0]  p1_rdata,
  output logic [dbytes-1:0]       ram_we,
  output logic [abits-1:0]        ram_addr,
  output logic [dbytes*blen-1:0]  ram_wdata,
  input  logic [dbytes*blen-1:0]  ram_rdata,
  output logic [1:0]              o_dbg_owner,
  output logic                    o_dbg_last_gnt
);
  localparam int dbits = dbytes * blen;

  // Handshake: a transfer happens in the cycle where pN_req && pN_gnt; pN_rvalid pulses exactly one cycle later.
  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_LOCK0 = 2'd1,
    OWN_LOCK1 = 2'd2
  } owner_t;

  owner_t             r_owner;
  logic               r_last_gnt;
  logic [1:0]         r_rvalid;
  logic [abits-1:0]   r_addr_hold;
  logic [dbits-1:0]   r_wdata_hold;
  logic               w_gnt0;
  logic               w_gnt1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      case (r_owner)
        OWN_LOCK0: w_gnt0 = p0_req;
        OWN_LOCK1: w_gnt1 = p1_req;
        default: begin
          if (p0_req && p1_req) begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
            w_gnt0 = r_last_gnt;
            w_gnt1 = ~r_last_gnt;
`else
            w_gnt0 = 1'b1;
`endif
          end else begin
            w_gnt0 = p0_req;
            w_gnt1 = p1_req;
          end
        end
      endcase
    end
  end

  // Idle cycles keep the RAM address/data stable at the last transferred values.
  always_comb begin
    ram_we    = '0;
    ram_addr  = r_addr_hold;
    ram_wdata = r_wdata_hold;
    if (w_gnt0) begin
      ram_we    = p0_we;
      ram_addr  = p0_addr;
      ram_wdata = p0_wdata;
    end else if (w_gnt1) begin
      ram_we    = p1_we;
      ram_addr  = p1_addr;
      ram_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWN_IDLE;
      r_last_gnt   <= 1'b1;
      r_rvalid     <= 2'b00;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_rvalid <= {w_gnt1, w_gnt0};
      if (w_gnt0 || w_gnt1) begin
        r_last_gnt   <= w_gnt1;
        r_addr_hold  <= ram_addr;
        r_wdata_hold <= ram_wdata;
      end
      case (r_owner)
        OWN_IDLE: begin
          if (w_gnt0 && p0_lock)      r_owner <= OWN_LOCK0;
          else if (w_gnt1 && p1_lock) r_owner <= OWN_LOCK1;
        end
        // While locked, req implies grant, so dropping lock covers both exit cases.
        OWN_LOCK0: if (!p0_lock) r_owner <= OWN_IDLE;
        OWN_LOCK1: if (!p1_lock) r_owner <= OWN_IDLE;
        default:   r_owner <= OWN_IDLE;
      endcase
    end
  end

  assign p0_gnt         = w_gnt0;
  assign p1_gnt         = w_gnt1;
  assign p0_rvalid      = r_rvalid[0];
  assign p1_rvalid      = r_rvalid[1];
  assign p0_rdata       = ram_rdata;
  assign p1_rdata       = ram_rdata;
  assign o_dbg_owner    = r_owner;
  assign o_dbg_last_gnt = r_last_gnt;

endmodule
